// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types and constants for the two-port memory arbiter:
//   arb_state_t : arbiter FSM states (idle, memory access in flight, response)
//   PORT_INSTR / PORT_DATA : port indices (instruction cache, data cache)
//   op_t        : memory operation latched at grant time
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage : memory_arbiter_pkg

// File: rtl/arbiter_grant_select.sv
// arbiter_grant_select
// Combinational choice of which pending port to serve next.
// Build option: MEMORY_ARBITER_ROUND_ROBIN_EN
//   defined   : on a tie, the port other than last_grant_i wins
//   undefined : fixed priority, port 1 (data side) over port 0
// Ports:
//   pending_i     [1:0] per-port pending request (bit N = port N)
//   last_grant_i        index of the most recently granted port
//   grant_valid_o       at least one port is pending
//   grant_idx_o         index of the selected port (meaningful with grant_valid_o)
module arbiter_grant_select
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] pending_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // Round-robin selection: alternate on ties, otherwise the lone pending port.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = PORT_INSTR;
    case (pending_i)
      2'b01: begin
        grant_valid_o = 1'b1;
        grant_idx_o   = PORT_INSTR;
      end
      2'b10: begin
        grant_valid_o = 1'b1;
        grant_idx_o   = PORT_DATA;
      end
      2'b11: begin
        grant_valid_o = 1'b1;
        grant_idx_o   = ~last_grant_i;
      end
      default: begin
        grant_valid_o = 1'b0;
        grant_idx_o   = PORT_INSTR;
      end
    endcase
  end
`else
  // History is kept by the top level but does not influence fixed priority.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_i;

  // Fixed-priority selection: data side wins whenever it is pending.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = PORT_INSTR;
    if (pending_i[1]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = PORT_DATA;
    end else if (pending_i[0]) begin
      grant_valid_o = 1'b1;
      grant_idx_o   = PORT_INSTR;
    end else begin
      grant_valid_o = 1'b0;
      grant_idx_o   = PORT_INSTR;
    end
  end
`endif

endmodule : arbiter_grant_select

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one main-memory interface between the instruction cache (port 0)
// and the data cache (port 1). Requests are level-held until a one-cycle
// response pulse; transactions are serialised IDLE -> BUSY -> DONE -> IDLE,
// so one idle cycle always separates back-to-back transactions.
// Build option: MEMORY_ARBITER_ROUND_ROBIN_EN (see arbiter_grant_select).
// Ports:
//   clk_i, rst_n_i                      clock, synchronous active-low reset
//   pN_read_request_i/pN_write_request_i  level request from port N (write wins)
//   pN_addr_i, pN_write_data_i          port N address / write data
//   pN_response_o, pN_read_data_o       completion pulse / captured read data
//   memory_*_o                          registered request, address, write data
//   memory_response_i, memory_read_data_i  memory completion and read data
//   busy_o                              transaction in BUSY or DONE
//   grant_o                             port last or currently granted
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  p0_read_request_i,
  input  logic                  p0_write_request_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_write_data_i,
  output logic                  p0_response_o,
  output logic [DATA_WIDTH-1:0] p0_read_data_o,
  input  logic                  p1_read_request_i,
  input  logic                  p1_write_request_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_write_data_i,
  output logic                  p1_response_o,
  output logic [DATA_WIDTH-1:0] p1_read_data_o,
  output logic                  memory_read_request_o,
  output logic                  memory_write_request_o,
  output logic [ADDR_WIDTH-1:0] memory_addr_o,
  output logic [DATA_WIDTH-1:0] memory_write_data_o,
  input  logic                  memory_response_i,
  input  logic [DATA_WIDTH-1:0] memory_read_data_i,
  output logic                  busy_o,
  output logic                  grant_o
);

  arb_state_t            state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  p0_resp_q, p0_resp_d;
  logic                  p1_resp_q, p1_resp_d;
  logic                  busy_q, busy_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;

  logic [1:0]            pending_s;
  logic                  grant_valid_s;
  logic                  grant_idx_s;

  assign pending_s = {p1_read_request_i | p1_write_request_i,
                      p0_read_request_i | p0_write_request_i};

  arbiter_grant_select u_grant_select (
    .pending_i     (pending_s),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_s),
    .grant_idx_o   (grant_idx_s)
  );

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    p0_resp_d    = 1'b0;
    p1_resp_d    = 1'b0;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid_s) begin
          state_d      = ARB_BUSY;
          grant_d      = grant_idx_s;
          last_grant_d = grant_idx_s;
          busy_d       = 1'b1;
          // A write held together with a read on the same port is served as a write.
          if (grant_idx_s == PORT_DATA) begin
            addr_d  = p1_addr_i;
            wdata_d = p1_write_data_i;
            op_d    = p1_write_request_i ? OP_WRITE : OP_READ;
          end else begin
            addr_d  = p0_addr_i;
            wdata_d = p0_write_data_i;
            op_d    = p0_write_request_i ? OP_WRITE : OP_READ;
          end
          mem_rd_d = (op_d == OP_READ);
          mem_wr_d = (op_d == OP_WRITE);
        end else begin
          state_d = ARB_IDLE;
          busy_d  = 1'b0;
        end
      end
      ARB_BUSY: begin
        if (memory_response_i) begin
          // Writes capture too; the requester ignores the value.
          data_d    = memory_read_data_i;
          state_d   = ARB_DONE;
          p0_resp_d = (grant_q == PORT_INSTR);
          p1_resp_d = (grant_q == PORT_DATA);
        end else begin
          mem_rd_d = (op_q == OP_READ);
          mem_wr_d = (op_q == OP_WRITE);
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ARB_IDLE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      p0_resp_q    <= 1'b0;
      p1_resp_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      p0_resp_q    <= p0_resp_d;
      p1_resp_q    <= p1_resp_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign memory_read_request_o  = mem_rd_q;
  assign memory_write_request_o = mem_wr_q;
  assign memory_addr_o          = addr_q;
  assign memory_write_data_o    = wdata_q;
  assign p0_response_o          = p0_resp_q;
  assign p1_response_o          = p1_resp_q;
  assign p0_read_data_o         = data_q;
  assign p1_read_data_o         = data_q;
  assign busy_o                 = busy_q;
  assign grant_o                = grant_q;

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed stimulus for memory_arbiter with a scoreboard: expected memory
// transactions and port responses are queued when stimulus is issued, and a
// monitor pops and compares them whenever the DUT presents them.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_rd, p0_wr, p1_rd, p1_wr;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_resp, p1_resp;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata_in;
  logic        busy, grant;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i                  (clk),
    .rst_n_i                (rst_n),
    .p0_read_request_i      (p0_rd),
    .p0_write_request_i     (p0_wr),
    .p0_addr_i              (p0_addr),
    .p0_write_data_i        (p0_wdata),
    .p0_response_o          (p0_resp),
    .p0_read_data_o         (p0_rdata),
    .p1_read_request_i      (p1_rd),
    .p1_write_request_i     (p1_wr),
    .p1_addr_i              (p1_addr),
    .p1_write_data_i        (p1_wdata),
    .p1_response_o          (p1_resp),
    .p1_read_data_o         (p1_rdata),
    .memory_read_request_o  (mem_rd),
    .memory_write_request_o (mem_wr),
    .memory_addr_o          (mem_addr),
    .memory_write_data_o    (mem_wdata),
    .memory_response_i      (mem_resp),
    .memory_read_data_i     (mem_rdata_in),
    .busy_o                 (busy),
    .grant_o                (grant)
  );

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  int       total = 0;
  int       bad   = 0;

  // memory model controls
  int          mem_delay  = 1;
  logic [31:0] mem_rdata  = 32'h0;
  logic        model_resp = 1'b0;
  logic        stray_resp = 1'b0;
  int          mcnt       = 0;

  assign mem_resp     = model_resp | stray_resp;
  assign mem_rdata_in = mem_rdata;

  // per-run observations
  int rise_at[$];
  int resp_at[$];
  int rd_cyc, wr_cyc;
  logic busy_at_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory model: answer in the mem_delay-th cycle a request is held.
  initial begin
    forever begin
      @(negedge clk);
      model_resp = 1'b0;
      if (mem_rd || mem_wr) begin
        mcnt++;
        if (mcnt == mem_delay) model_resp = 1'b1;
      end else begin
        mcnt = 0;
      end
    end
  end

  // Monitor: compare memory transactions and port responses with the queues.
  initial begin
    logic prev_req = 1'b0, prev_p0 = 1'b0, prev_p1 = 1'b0;
    mem_exp_t me;
    rsp_exp_t re;
    forever begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && !prev_req) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          me = mem_q.pop_front();
          check("mem_grant", 64'(grant), 64'(me.port));
          check("mem_write_req", 64'(mem_wr), 64'(me.wr));
          check("mem_read_req", 64'(mem_rd), 64'(!me.wr));
          check("mem_addr", 64'(mem_addr), 64'(me.addr));
          if (me.wr) check("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
        end
      end
      if (p0_resp || p1_resp) begin
        if (p0_resp && p1_resp) check("both_resp", 64'd1, 64'd0);
        if ((p0_resp && prev_p0) || (p1_resp && prev_p1)) check("resp_pulse_width", 64'd2, 64'd1);
        if (rsp_q.size() == 0) begin
          check("unexpected_resp", {62'd0, p1_resp, p0_resp}, 64'd0);
        end else begin
          re = rsp_q.pop_front();
          check("resp_port", 64'(p1_resp), 64'(re.port));
          check("p0_read_data", 64'(p0_rdata), 64'(re.data));
          check("p1_read_data", 64'(p1_rdata), 64'(re.data));
        end
      end
      prev_req = mem_rd || mem_wr;
      prev_p0  = p0_resp;
      prev_p1  = p1_resp;
    end
  end

  // Run until n responses arrive; requester drops its request at the sampling edge.
  task automatic run(input int n);
    int   got = 0;
    int   cycles = 0;
    logic prev = 1'b0;
    logic d0, d1;
    rise_at.delete();
    resp_at.delete();
    rd_cyc = 0;
    wr_cyc = 0;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if ((mem_rd || mem_wr) && !prev) rise_at.push_back(cycles - 1);
      prev = mem_rd || mem_wr;
      d0 = p0_resp;
      d1 = p1_resp;
      if (d0 || d1) begin
        resp_at.push_back(cycles - 1);
        busy_at_resp = busy;
      end
      @(posedge clk);
      #1;
      if (d0) begin p0_rd = 1'b0; p0_wr = 1'b0; got++; end
      if (d1) begin p1_rd = 1'b0; p1_wr = 1'b0; got++; end
    end
    if (got < n) check("response_timeout", 64'(got), 64'(n));
  endtask

  task automatic push_dual(input logic port);
    mem_exp_t me;
    rsp_exp_t re;
    me.port  = port;
    me.wr    = port;
    me.addr  = port ? 32'h0000_0200 : 32'h0000_0100;
    me.wdata = port ? 32'h1234_5678 : 32'h0;
    mem_q.push_back(me);
    re.port = port;
    re.data = 32'hCAFE_0001;
    rsp_q.push_back(re);
  endtask

  task automatic dual(input logic first);
    push_dual(first);
    push_dual(~first);
    p0_rd = 1'b1; p0_addr = 32'h0000_0100;
    p1_wr = 1'b1; p1_addr = 32'h0000_0200; p1_wdata = 32'h1234_5678;
    run(2);
    if (rise_at.size() == 2 && resp_at.size() == 2)
      check("idle_gap", 64'(rise_at[1] - resp_at[0]), 64'd2);
    else
      check("dual_event_count", 64'(rise_at.size()), 64'd2);
  endtask

  initial begin
    mem_exp_t me;
    rsp_exp_t re;
    logic first;
    logic any_resp;
    rst_n = 1'b0;
    p0_rd = 1'b0; p0_wr = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_rd = 1'b0; p1_wr = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_resp", {62'd0, p1_resp, p0_resp}, 64'd0);
    check("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);

    // single read on port 0, memory answers in its third request cycle
    @(posedge clk); #1;
    mem_delay = 3; mem_rdata = 32'hDEAD_BEEF;
    me.port = 1'b0; me.wr = 1'b0; me.addr = 32'h0000_0040; me.wdata = 32'h0;
    mem_q.push_back(me);
    re.port = 1'b0; re.data = 32'hDEAD_BEEF;
    rsp_q.push_back(re);
    p0_rd = 1'b1; p0_addr = 32'h0000_0040;
    run(1);
    check("single_rd_cycles", 64'(rd_cyc), 64'd3);
    check("single_wr_cycles", 64'(wr_cyc), 64'd0);

    // simultaneous p0 read / p1 write, issued twice
    @(posedge clk); #1;
    mem_delay = 2; mem_rdata = 32'hCAFE_0001;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    dual(first);
    @(posedge clk); #1;
    dual(first);

    // read and write both held on port 1: served as a write
    @(posedge clk); #1;
    me.port = 1'b1; me.wr = 1'b1; me.addr = 32'h0000_0008; me.wdata = 32'h0000_0055;
    mem_q.push_back(me);
    re.port = 1'b1; re.data = 32'hCAFE_0001;
    rsp_q.push_back(re);
    p1_rd = 1'b1; p1_wr = 1'b1; p1_addr = 32'h0000_0008; p1_wdata = 32'h0000_0055;
    run(1);
    check("rw_rd_cycles", 64'(rd_cyc), 64'd0);
    check("rw_wr_cycles", 64'(wr_cyc), 64'd2);

    // reset during BUSY abandons the transaction
    @(posedge clk); #1;
    mem_delay = 10;
    me.port = 1'b0; me.wr = 1'b0; me.addr = 32'h0000_0300; me.wdata = 32'h0;
    mem_q.push_back(me);
    p0_rd = 1'b1; p0_addr = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_mem_rd", 64'(mem_rd), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; p0_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_mem_req", {62'd0, mem_rd, mem_wr}, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    any_resp = p0_resp | p1_resp;
    @(posedge clk); #1 stray_resp = 1'b1;
    @(posedge clk); #1 stray_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any_resp = any_resp | p0_resp | p1_resp | busy | mem_rd | mem_wr;
    end
    check("stray_resp_ignored", 64'(any_resp), 64'd0);

    // memory answers in the first BUSY cycle: minimum latency
    @(posedge clk); #1;
    mem_delay = 1; mem_rdata = 32'h0BAD_F00D;
    me.port = 1'b1; me.wr = 1'b0; me.addr = 32'h0000_0044; me.wdata = 32'h0;
    mem_q.push_back(me);
    re.port = 1'b1; re.data = 32'h0BAD_F00D;
    rsp_q.push_back(re);
    p1_rd = 1'b1; p1_addr = 32'h0000_0044;
    run(1);
    if (resp_at.size() == 1) check("min_latency", 64'(resp_at[0]), 64'd2);
    else check("min_latency_resp_count", 64'(resp_at.size()), 64'd1);
    check("busy_at_resp", 64'(busy_at_resp), 64'd1);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);

    repeat (2) @(negedge clk);
    check("mem_queue_empty", 64'(mem_q.size()), 64'd0);
    check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_memory_arbiter

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-port arbiter that shares one main-memory interface between the instruction-side cache (port 0) and the data-side cache (port 1). Each port uses the cache-to-memory handshake: level-held read/write request, one-cycle response pulse. The block serialises transactions, drives the memory with registered address, data and request, and routes the returned data and response back to the granted port. It sits between the two cache instances and the memory model in the processor top level.

Parameters:
ADDR_WIDTH, 32, width of address on both ports and memory side
DATA_WIDTH, 32, width of read/write data on both ports and memory side

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
p0_read_request  input  1  port 0 read request, held until p0_response
p0_write_request  input  1  port 0 write request, held until p0_response
p0_addr  input  ADDR_WIDTH  port 0 address
p0_write_data  input  DATA_WIDTH  port 0 write data
p0_response  output  1  one-cycle completion pulse to port 0
p0_read_data  output  DATA_WIDTH  read data for port 0, valid with p0_response
p1_read_request, p1_write_request, p1_addr, p1_write_data, p1_response, p1_read_data  same as port 0, for port 1
memory_read_request  output  1  registered read request to memory
memory_write_request  output  1  registered write request to memory
memory_addr  output  ADDR_WIDTH  registered memory address
memory_write_data  output  DATA_WIDTH  registered memory write data
memory_response  input  1  memory completion pulse
memory_read_data  input  DATA_WIDTH  memory read data, valid with memory_response
busy  output  1  high in ARB_BUSY and ARB_DONE
grant  output  1  index of the port last or currently granted

Behaviour:
- Reset (rst_n low at a clock edge): state goes to ARB_IDLE. All outputs go to 0: responses, memory requests, memory_addr, memory_write_data, read data, busy, grant. last_grant goes to 1.
- Port pending = read_request | write_request. If both are high on one port, the write takes precedence and is served as a write.
- ARB_IDLE:
  - If no port is pending, stay in ARB_IDLE.
  - Otherwise select a port (see priority rule). Latch its addr, write_data and op (read or write) into memory_addr, memory_write_data and the op register. Set grant. Go to ARB_BUSY.
- ARB_BUSY:
  - memory_read_request = !op; memory_write_request = op. Both are held stable for the whole state.
  - On memory_response, capture memory_read_data into the data register (writes capture too and the value is ignored). Go to ARB_DONE.
- ARB_DONE:
  - Both memory requests are low.
  - pN_response is high for exactly one cycle on the granted port only.
  - p0_read_data and p1_read_data both drive the captured data register.
  - Go to ARB_IDLE.
- Requester rule: the requester deasserts its request at the same edge where it samples the response, so its request is low in the following ARB_IDLE cycle. A request dropped during ARB_BUSY is not permitted; if it happens, the arbiter completes the transaction and still pulses the response.
- Latency:
  - Request seen in ARB_IDLE (cycle 0) → memory request at cycle 1.
  - memory_response at cycle k≥1 → pN_response at cycle k+1.
  - Minimum latency is 2 cycles. One idle cycle is forced between back-to-back transactions.
- memory_response in ARB_IDLE or ARB_DONE is ignored.
- A request from the non-granted port during ARB_BUSY/ARB_DONE waits and is arbitrated in the next ARB_IDLE.
- Reset mid-transaction: the transaction is abandoned and the memory requests drop in the cycle after the reset edge. No response is issued.
- Default priority (macro absent): fixed, port 1 over port 0 when both are pending in ARB_IDLE.

Optional Feature:
MEMORY_ARBITER_ROUND_ROBIN_EN
- Defined: when both ports are pending in ARB_IDLE, grant the port != last_grant. last_grant updates on every grant and resets to 1, so port 0 wins the first tie. A single pending port is always granted.
- Undefined: fixed priority as above. The last_grant register is still present but does not affect selection.

Decomposition:
- Package memory_arbiter_pkg:
  - typedef arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_DONE}
  - localparams PORT_INSTR=0, PORT_DATA=1
  - typedef op_t {OP_READ=0, OP_WRITE=1}
- Sub-module arbiter_grant_select: combinational block, inputs pending[1:0] and last_grant; outputs grant_valid and grant_idx. The priority/round-robin macro lives here only.

Test Plan:
- Single read: p0_read_request, p0_addr=0x0000_0040; memory responds 3 cycles after its request with 0xDEAD_BEEF → memory_addr=0x40, memory_read_request high 3 cycles, p0_response one pulse, p0_read_data=0xDEAD_BEEF, p1_response stays 0.
- Simultaneous p0 read 0x100 and p1 write 0x200 / 0x1234_5678 with macro undefined → p1 write served first (memory_write_data=0x1234_5678), one idle cycle, then p0 read of 0x100.
- Same simultaneous stimulus repeated twice with MEMORY_ARBITER_ROUND_ROBIN_EN → grants in order 0,1,0,1.
- Both read and write high on p1, addr 0x8 → memory_write_request only, memory_read_request never high.
- rst_n low for one cycle during ARB_BUSY → next cycle memory requests 0, busy 0, no response. A later memory_response pulse is ignored.
- Memory responds in the first BUSY cycle → pN_response exactly 2 cycles after the request was first sampled, and busy falls the following cycle.
